// File: rtl/mips_mem_pkg.sv
// rtl/mips_mem_pkg.sv - shared store-buffer defaults, pointer width and entry type
package mips_mem_pkg;

    localparam int SB_DEPTH = 4;
    localparam int SB_AW    = 32;
    localparam int SB_DW    = 32;
    localparam int SB_PTR_W = $clog2(SB_DEPTH);

    typedef struct packed {
        logic [SB_AW-1:0] addr;
        logic [SB_DW-1:0] data;
        logic             valid;
    } sb_entry_t;

endpackage

// File: rtl/store_buffer_match.sv
// rtl/store_buffer_match.sv - youngest-first address match over the buffer entries
module store_buffer_match
    import mips_mem_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH,
    parameter int WW    = SB_AW - 2,
    parameter int DW    = SB_DW,
    parameter int PW    = $clog2(DEPTH)
) (
    input  logic [WW-1:0]    waddr_i [DEPTH],
    input  logic [DW-1:0]    data_i  [DEPTH],
    input  logic [DEPTH-1:0] valid_i,
    input  logic [PW-1:0]    tail_i,
    input  logic [WW-1:0]    lookup_i,
    output logic             hit_o,
    output logic [PW-1:0]    idx_o,
    output logic [DW-1:0]    data_o
);

    logic [PW-1:0] slot;
    logic          found;

    // Walk backwards from tail-1 (youngest) to tail (oldest); first valid match wins.
    always_comb begin
        found  = 1'b0;
        idx_o  = '0;
        data_o = '0;
        slot   = '0;
        for (int i = 1; i <= DEPTH; i++) begin
            slot = tail_i - PW'(i);
            if (!found && valid_i[slot] && (waddr_i[slot] == lookup_i)) begin
                found  = 1'b1;
                idx_o  = slot;
                data_o = data_i[slot];
            end
        end
        hit_o = found;
    end

endmodule

// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - posted-write FIFO with load forwarding; STORE_BUFFER_COALESCE_EN enables store coalescing
module store_buffer
    import mips_mem_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH,
    parameter int AW    = SB_AW,
    parameter int DW    = SB_DW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          memwritem,
    input  logic [AW-1:0] aluoutm,
    input  logic [DW-1:0] writedatam,
    output logic [DW-1:0] readdata,
    output logic          mem_we,
    output logic [AW-1:0] mem_waddr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_ready,
    output logic [AW-1:0] mem_raddr,
    input  logic [DW-1:0] mem_rdata,
    output logic          full,
    output logic          empty,
    output logic          overflow
);

    localparam int              PW       = $clog2(DEPTH);
    localparam logic [PW:0]     CNT_FULL = (PW+1)'(DEPTH);
    localparam logic [PW:0]     CNT_ONE  = (PW+1)'(1);
    localparam logic [PW-1:0]   PTR_ONE  = PW'(1);
`ifdef STORE_BUFFER_COALESCE_EN
    localparam bit              COALESCE_EN = 1'b1;
`else
    localparam bit              COALESCE_EN = 1'b0;
`endif

    logic [AW-1:0]    addr_q  [DEPTH];
    logic [AW-1:0]    addr_d  [DEPTH];
    logic [DW-1:0]    data_q  [DEPTH];
    logic [DW-1:0]    data_d  [DEPTH];
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [PW-1:0]    head_q, head_d;
    logic [PW-1:0]    tail_q, tail_d;
    logic [PW:0]      count_q, count_d;
    logic             overflow_q, overflow_d;

    logic [AW-3:0]    waddr_w [DEPTH];
    logic             m_hit;
    logic [PW-1:0]    m_idx;
    logic [DW-1:0]    m_data;

    logic             pop;
    logic             push;
    logic             coalesce;
    logic             drop;
    logic [PW-1:0]    youngest;

    // Word addresses of every entry, fed to the shared match search.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            waddr_w[i] = addr_q[i][AW-1:2];
        end
    end

    store_buffer_match #(
        .DEPTH (DEPTH),
        .WW    (AW - 2),
        .DW    (DW),
        .PW    (PW)
    ) u_match (
        .waddr_i  (waddr_w),
        .data_i   (data_q),
        .valid_i  (valid_q),
        .tail_i   (tail_q),
        .lookup_i (aluoutm[AW-1:2]),
        .hit_o    (m_hit),
        .idx_o    (m_idx),
        .data_o   (m_data)
    );

    // Head-of-queue drive to memory and status flags, all from registered state.
    always_comb begin
        mem_we    = valid_q[head_q];
        mem_waddr = addr_q[head_q];
        mem_wdata = data_q[head_q];
        mem_raddr = aluoutm;
        full      = (count_q == CNT_FULL);
        empty     = (count_q == '0);
        overflow  = overflow_q;
        readdata  = m_hit ? m_data : mem_rdata;
    end

    // Push/pop/coalesce decisions and next-state of the FIFO.
    always_comb begin
        addr_d     = addr_q;
        data_d     = data_q;
        valid_d    = valid_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        overflow_d = overflow_q;

        youngest = tail_q - PTR_ONE;
        pop      = valid_q[head_q] & mem_ready;
        // Merge into the youngest entry only if it is the one that matched and
        // it is not leaving the buffer at this edge.
        coalesce = COALESCE_EN && memwritem && m_hit && (m_idx == youngest)
                   && !((youngest == head_q) && pop);
        push     = memwritem && !coalesce && ((count_q != CNT_FULL) || pop);
        drop     = memwritem && !coalesce && (count_q == CNT_FULL) && !pop;

        if (coalesce) begin
            data_d[m_idx] = writedatam;
        end
        if (pop) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + PTR_ONE;
        end
        // Push after pop so a full buffer reusing the head slot ends up valid.
        if (push) begin
            addr_d[tail_q]  = aluoutm;
            data_d[tail_q]  = writedatam;
            valid_d[tail_q] = 1'b1;
            tail_d          = tail_q + PTR_ONE;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
        if (drop) begin
            overflow_d = 1'b1;
        end
    end

    // Control state: pointers, occupancy, valid bits and the sticky overflow flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q    <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            valid_q    <= valid_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Entry payload; meaningless while the matching valid bit is clear, so not reset.
    always_ff @(posedge clk) begin
        addr_q <= addr_d;
        data_q <= data_d;
    end

endmodule

// File: tb/tb_store_buffer.sv
// tb/tb_store_buffer.sv - randomized and directed self-checking bench for store_buffer
module tb_store_buffer;
    import mips_mem_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        memwritem = 1'b0;
    logic [31:0] aluoutm = '0;
    logic [31:0] writedatam = '0;
    logic [31:0] readdata;
    logic        mem_we;
    logic [31:0] mem_waddr;
    logic [31:0] mem_wdata;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_raddr;
    logic [31:0] mem_rdata = '0;
    logic        full;
    logic        empty;
    logic        overflow;

    int n_cmp = 0;
    int n_bad = 0;

    sb_entry_t   mq[$];
    bit          m_ovf = 1'b0;
    logic [31:0] wr_addr_log[$];
    logic [31:0] wr_data_log[$];

    store_buffer #(.DEPTH(DEPTH), .AW(32), .DW(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .memwritem  (memwritem),
        .aluoutm    (aluoutm),
        .writedatam (writedatam),
        .readdata   (readdata),
        .mem_we     (mem_we),
        .mem_waddr  (mem_waddr),
        .mem_wdata  (mem_wdata),
        .mem_ready  (mem_ready),
        .mem_raddr  (mem_raddr),
        .mem_rdata  (mem_rdata),
        .full       (full),
        .empty      (empty),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_load(input logic [31:0] a, input logic [31:0] rd);
        for (int i = mq.size() - 1; i >= 0; i--) begin
            if (mq[i].addr[31:2] == a[31:2]) return mq[i].data;
        end
        return rd;
    endfunction

    task automatic drive(input bit rst, input bit we, input logic [31:0] a,
                         input logic [31:0] d, input bit rdy, input logic [31:0] rd);
        @(negedge clk);
        reset = rst; memwritem = we; aluoutm = a; writedatam = d;
        mem_ready = rdy; mem_rdata = rd;
        #1;
        check("mem_we", mem_we, mq.size() != 0);
        if (mq.size() != 0) begin
            check("mem_waddr", mem_waddr, mq[0].addr);
            check("mem_wdata", mem_wdata, mq[0].data);
        end
        check("full", full, mq.size() == DEPTH);
        check("empty", empty, mq.size() == 0);
        check("overflow", overflow, m_ovf);
        check("readdata", readdata, model_load(a, rd));
        check("mem_raddr", mem_raddr, a);
        if (!rst && mem_we && mem_ready) begin
            wr_addr_log.push_back(mem_waddr);
            wr_data_log.push_back(mem_wdata);
        end
    endtask

    task automatic commit();
        bit pop;
        bit coal;
        @(posedge clk);
        if (reset) begin
            mq.delete();
            m_ovf = 1'b0;
        end else begin
            pop  = (mq.size() != 0) && mem_ready;
            coal = 1'b0;
`ifdef STORE_BUFFER_COALESCE_EN
            if (memwritem && mq.size() != 0 && mq[mq.size()-1].addr[31:2] == aluoutm[31:2]
                && !(mq.size() == 1 && pop)) coal = 1'b1;
`endif
            if (coal) mq[mq.size()-1].data = writedatam;
            if (pop) void'(mq.pop_front());
            if (memwritem && !coal) begin
                if (mq.size() < DEPTH) mq.push_back('{addr: aluoutm, data: writedatam, valid: 1'b1});
                else m_ovf = 1'b1;
            end
        end
        #1;
    endtask

    task automatic step(input bit rst, input bit we, input logic [31:0] a,
                        input logic [31:0] d, input bit rdy, input logic [31:0] rd);
        drive(rst, we, a, d, rdy, rd);
        commit();
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    endtask

    initial begin
        logic [31:0] a;
        bit          rdy;
        int          stall;

        do_reset();
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0BAD_F00D);
        check("rst_mem_we", mem_we, 1'b0);
        check("rst_empty", empty, 1'b1);
        check("rst_full", full, 1'b0);
        check("rst_overflow", overflow, 1'b0);
        check("rst_readdata", readdata, 32'h0BAD_F00D);

        // Single store then drain.
        step(1'b0, 1'b1, 32'h100, 32'hDEAD_BEEF, 1'b1, 32'h0);
        check("t1_we", mem_we, 1'b1);
        check("t1_waddr", mem_waddr, 32'h100);
        check("t1_wdata", mem_wdata, 32'hDEAD_BEEF);
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h0);
        check("t1_empty", empty, 1'b1);

        // Fill and overflow, then in-order drain.
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 32'(i * 4), 32'(100 + i), 1'b0, 32'h0);
        check("t2_full", full, 1'b1);
        check("t2_overflow", overflow, 1'b1);
        wr_addr_log.delete(); wr_data_log.delete();
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h0);
        check("t2_drain_cnt", wr_addr_log.size(), 4);
        for (int i = 0; i < 4 && i < wr_addr_log.size(); i++) check("t2_drain_addr", wr_addr_log[i], 32'(i * 4));
        check("t2_ovf_sticky", overflow, 1'b1);
        do_reset();

        // Forwarding priority.
        step(1'b0, 1'b1, 32'h20, 32'd1, 1'b0, 32'h0);
        step(1'b0, 1'b1, 32'h20, 32'd2, 1'b0, 32'h0);
        drive(1'b0, 1'b0, 32'h20, 32'h0, 1'b0, 32'h5555_5555);
        check("t3_fwd_young", readdata, 32'd2);
        commit();
        drive(1'b0, 1'b0, 32'h24, 32'h0, 1'b0, 32'h1234_5678);
        check("t3_fwd_miss", readdata, 32'h1234_5678);
        commit();
        do_reset();

        // Full with simultaneous pop.
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 32'h30 + 32'(i * 4), 32'(i), 1'b0, 32'h0);
        step(1'b0, 1'b1, 32'h40, 32'h40, 1'b1, 32'h0);
        check("t4_full", full, 1'b1);
        check("t4_no_ovf", overflow, 1'b0);
        check("t4_head", mem_waddr, 32'h34);
        do_reset();

        // Reset mid-operation.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 32'h60 + 32'(i * 4), 32'(i), 1'b0, 32'h0);
        step(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        wr_addr_log.delete(); wr_data_log.delete();
        check("t5_we", mem_we, 1'b0);
        check("t5_empty", empty, 1'b1);
        check("t5_ovf", overflow, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h0);
        check("t5_no_writes", wr_addr_log.size(), 0);

        // Same-address back-to-back stores: merged only with coalescing.
        step(1'b0, 1'b1, 32'h80, 32'd5, 1'b0, 32'h0);
        step(1'b0, 1'b1, 32'h80, 32'd6, 1'b0, 32'h0);
        wr_addr_log.delete(); wr_data_log.delete();
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h0);
`ifdef STORE_BUFFER_COALESCE_EN
        check("t6_writes", wr_data_log.size(), 1);
        if (wr_data_log.size() > 0) check("t6_data", wr_data_log[0], 32'd6);
`else
        check("t6_writes", wr_data_log.size(), 2);
        if (wr_data_log.size() > 1) begin
            check("t6_data0", wr_data_log[0], 32'd5);
            check("t6_data1", wr_data_log[1], 32'd6);
        end
`endif
        do_reset();

        // Randomized traffic with bursty memory back-pressure.
        stall = 0;
        for (int c = 0; c < 3000; c++) begin
            a = {26'($urandom_range(0, 15)), 4'b0000, 2'($urandom)};
            if (stall > 0) begin
                stall--;
                rdy = 1'b0;
            end else begin
                rdy = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 40) == 0) stall = $urandom_range(3, 12);
            end
            step($urandom_range(0, 300) == 0, $urandom_range(0, 1) == 1, a, $urandom, rdy, $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
